// File: rtl/nes_pkg.sv
// Shared definitions for the NES gamepad reader: FSM states, button bit
// positions within the button byte, and the pad's serial bit count.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LATCH      = 3'd1,
        PULSE_HIGH = 3'd2,
        PULSE_LOW  = 3'd3,
        DONE       = 3'd4
    } nes_state_t;

    localparam int NES_BITS   = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // The pad drives its data line low for a pressed button.
    function automatic logic sample_bit(input logic sd);
        return ~sd;
    endfunction

endpackage

// File: rtl/nes_input_synchronizer.sv
// Two-flop synchronizer for the pad's serial data line. Both flops reset to
// 1 so that a released (pulled-up) line is what the reader sees after reset.
module nes_input_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous pad line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/nes_controller_reader.sv
// NES gamepad reader: on each poll strobe, raises LATCH for two phases, then
// issues eight PULSE periods while shifting in the serial button bits. Bit 0
// is taken at the end of LATCH, bit k at the end of the low phase after
// pulse k; the eighth pulse is issued for the pad but samples nothing. The
// completed byte is published in DONE together with a one-cycle valid strobe.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int PHASE_CYCLES = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       poll_enable,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int CNT_W = $clog2(2 * PHASE_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX   = 4'(NES_BITS);

    nes_state_t       state_r;
    logic [CNT_W-1:0] timer_r;
    logic [3:0]       bit_idx_r;
    logic             pulse_seen_r;
    logic [7:0]       shift_r;
    logic             sd_s;

    nes_input_synchronizer u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (nes_data),
        .sync_out (sd_s)
    );

    // Read sequencer: phase timer, pad line drive, bit capture and publishing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            timer_r       <= '0;
            bit_idx_r     <= 4'd0;
            pulse_seen_r  <= 1'b0;
            shift_r       <= 8'h00;
            nes_latch     <= 1'b0;
            nes_pulse     <= 1'b0;
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            buttons_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    nes_latch <= 1'b0;
                    nes_pulse <= 1'b0;
                    busy      <= 1'b0;
                    timer_r   <= '0;
                    if (poll_enable) begin
                        state_r      <= LATCH;
                        nes_latch    <= 1'b1;
                        busy         <= 1'b1;
                        shift_r      <= 8'h00;
                        bit_idx_r    <= 4'd0;
                        pulse_seen_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LATCH: begin
                    if (timer_r == LATCH_LAST) begin
                        shift_r[BTN_A] <= sample_bit(sd_s);
                        bit_idx_r      <= 4'd1;
                        nes_latch      <= 1'b0;
                        timer_r        <= '0;
                        state_r        <= PULSE_LOW;
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                PULSE_HIGH: begin
                    if (timer_r == PHASE_LAST) begin
                        nes_pulse    <= 1'b0;
                        pulse_seen_r <= 1'b1;
                        timer_r      <= '0;
                        state_r      <= PULSE_LOW;
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                PULSE_LOW: begin
                    if (timer_r == PHASE_LAST) begin
                        timer_r <= '0;
                        // The gap right after LATCH has no preceding pulse.
                        if (pulse_seen_r && (bit_idx_r < LAST_IDX)) begin
                            shift_r[bit_idx_r[2:0]] <= sample_bit(sd_s);
                        end else begin
                            shift_r <= shift_r;
                        end
                        if (pulse_seen_r && (bit_idx_r == LAST_IDX)) begin
                            buttons       <= shift_r;
                            buttons_valid <= 1'b1;
                            state_r       <= DONE;
                        end else begin
                            nes_pulse <= 1'b1;
                            state_r   <= PULSE_HIGH;
                            if (pulse_seen_r) begin
                                bit_idx_r <= bit_idx_r + 4'd1;
                            end else begin
                                bit_idx_r <= bit_idx_r;
                            end
                        end
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    timer_r <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    nes_latch <= 1'b0;
                    nes_pulse <= 1'b0;
                    busy      <= 1'b0;
                    timer_r   <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a short phase (4 cycles) and
// a behavioural 4021-style pad model driving the serial data line.
module tb_nes_controller_reader;
    import nes_pkg::*;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       poll_enable = 1'b0;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    nes_controller_reader #(.PHASE_CYCLES(T)) dut (
        .clock         (clock),
        .reset         (reset),
        .poll_enable   (poll_enable),
        .nes_data      (nes_data),
        .nes_latch     (nes_latch),
        .nes_pulse     (nes_pulse),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .busy          (busy)
    );

    // Pad model: LATCH loads, each PULSE rising edge advances to next button.
    logic [7:0] pad_buttons = 8'h00;
    logic       pad_plugged = 1'b1;
    logic       pad_stuck_low = 1'b0;
    logic [3:0] pad_idx = 4'd0;

    always @(posedge nes_latch or posedge nes_pulse) begin
        if (nes_latch) pad_idx <= 4'd0;
        else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
    end

    assign nes_data = pad_stuck_low ? 1'b0 :
                      (!pad_plugged ? 1'b1 :
                      ((pad_idx < 4'd8) ? ~pad_buttons[pad_idx[2:0]] : 1'b0));

    // Running monitor of pad line activity, sampled on the falling edge.
    int   mon_rises = 0;
    int   mon_valids = 0;
    int   mon_latch_cycles = 0;
    int   mon_bad_width = 0;
    int   run_len = 0;
    logic pulse_prev = 1'b0;

    always @(negedge clock) begin
        if (nes_pulse && !pulse_prev) mon_rises++;
        if (nes_pulse) run_len++;
        else begin
            if (pulse_prev && run_len != T) mon_bad_width++;
            run_len = 0;
        end
        if (nes_latch) mon_latch_cycles++;
        if (buttons_valid) mon_valids++;
        pulse_prev = nes_pulse;
    end

    // Issue one poll and observe 100 cycles; optional extra polls at cycles x1/x2.
    task automatic run_read(input logic [7:0] pad, input int x1, input int x2,
                            output logic [7:0] got, output int valids, output int latch_n,
                            output int rises, output int bad_w, output int latency);
        int v0, l0, r0, b0, latch_at, valid_at;
        pad_buttons = pad;
        v0 = mon_valids; l0 = mon_latch_cycles; r0 = mon_rises; b0 = mon_bad_width;
        latch_at = -1; valid_at = -1; got = 8'hxx;
        @(negedge clock);
        poll_enable = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            poll_enable = (c == x1) || (c == x2);
            if (nes_latch && latch_at < 0) latch_at = c;
            if (buttons_valid) begin got = buttons; valid_at = c; end
        end
        poll_enable = 1'b0;
        @(negedge clock);
        valids  = mon_valids - v0;
        latch_n = mon_latch_cycles - l0;
        rises   = mon_rises - r0;
        bad_w   = mon_bad_width - b0;
        latency = (latch_at >= 0 && valid_at >= 0) ? (valid_at - latch_at) : -1;
    endtask

    logic [7:0] got;
    int valids, latch_n, rises, bad_w, latency;

    task automatic test_reset();
        int v0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({nes_latch, nes_pulse, buttons_valid, busy, buttons} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected %h", {nes_latch, nes_pulse, buttons_valid, busy, buttons}, 12'h000);
        end
        reset = 1'b0;
        v0 = mon_valids;
        repeat (100) @(negedge clock);
        n_cmp++;
        if ({nes_latch, nes_pulse, buttons_valid, busy, buttons} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_idle_outputs: got %h expected %h", {nes_latch, nes_pulse, buttons_valid, busy, buttons}, 12'h000);
        end
        n_cmp++;
        if (dut.state_r !== IDLE) begin
            n_bad++;
            $display("FAIL reset_idle_state: got %0d expected %0d", dut.state_r, IDLE);
        end
        n_cmp++;
        if (mon_valids - v0 != 0) begin
            n_bad++;
            $display("FAIL reset_idle_valids: got %0d expected 0", mon_valids - v0);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        exp = (8'h01 << BTN_A) | (8'h01 << BTN_START);
        run_read(exp, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h09) begin n_bad++; $display("FAIL basic_buttons: got %h expected %h", got, 8'h09); end
        n_cmp++;
        if (valids != 1) begin n_bad++; $display("FAIL basic_valids: got %0d expected 1", valids); end
        n_cmp++;
        if (latch_n != 2 * T) begin n_bad++; $display("FAIL basic_latch_len: got %0d expected %0d", latch_n, 2 * T); end
        n_cmp++;
        if (rises != 8) begin n_bad++; $display("FAIL basic_pulse_count: got %0d expected 8", rises); end
        n_cmp++;
        if (bad_w != 0) begin n_bad++; $display("FAIL basic_pulse_width: got %0d bad widths expected 0", bad_w); end
        n_cmp++;
        if (latency != 19 * T) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", latency, 19 * T); end
        n_cmp++;
        if (buttons !== 8'h09 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_hold_idle: got buttons %h busy %b expected 09 0", buttons, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_read(8'hFF, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'hFF) begin n_bad++; $display("FAIL all_pressed: got %h expected %h", got, 8'hFF); end
        pad_buttons = 8'h00;
        repeat (30) @(negedge clock);
        n_cmp++;
        if (buttons !== 8'hFF) begin n_bad++; $display("FAIL hold_between: got %h expected %h", buttons, 8'hFF); end
        run_read(8'h00, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h00 || valids != 1) begin
            n_bad++;
            $display("FAIL none_pressed: got %h valids %0d expected 00 1", got, valids);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] exp;
        exp = (8'h01 << BTN_A) | (8'h01 << BTN_SELECT) | (8'h01 << BTN_DOWN) | (8'h01 << BTN_RIGHT);
        run_read(exp, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'hA5) begin n_bad++; $display("FAIL pattern_a5: got %h expected %h", got, 8'hA5); end
        run_read(8'h3C, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h3C) begin n_bad++; $display("FAIL pattern_3c: got %h expected %h", got, 8'h3C); end
        exp = (8'h01 << BTN_UP) | (8'h01 << BTN_B);
        run_read(exp, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h12) begin n_bad++; $display("FAIL pattern_12: got %h expected %h", got, 8'h12); end
    endtask

    task automatic test_poll_while_busy();
        int active;
        logic [7:0] exp;
        exp = (8'h01 << BTN_B) | (8'h01 << BTN_LEFT);
        run_read(exp, 10, 40, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (valids != 1) begin n_bad++; $display("FAIL busy_poll_valids: got %0d expected 1", valids); end
        n_cmp++;
        if (got !== 8'h42 || latch_n != 2 * T) begin
            n_bad++;
            $display("FAIL busy_poll_read: got %h latch %0d expected 42 %0d", got, latch_n, 2 * T);
        end
        active = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (busy || nes_latch || nes_pulse) active++;
        end
        n_cmp++;
        if (active != 0) begin n_bad++; $display("FAIL busy_poll_not_queued: got %0d active cycles expected 0", active); end
        run_read(8'h24, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h24 || valids != 1) begin
            n_bad++;
            $display("FAIL busy_poll_next_read: got %h valids %0d expected 24 1", got, valids);
        end
    endtask

    task automatic test_reset_mid_read();
        int r0, v0, c;
        bit found;
        pad_buttons = 8'h81;
        r0 = mon_rises;
        found = 1'b0;
        @(negedge clock);
        poll_enable = 1'b1;
        @(negedge clock);
        poll_enable = 1'b0;
        for (c = 0; c < 200 && !found; c++) begin
            @(negedge clock);
            if (nes_pulse && (mon_rises - r0) == 3) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL reset_mid_find_pulse3: got timeout expected pulse 3 high"); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({nes_pulse, nes_latch, buttons_valid, busy, buttons} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h expected %h", {nes_pulse, nes_latch, buttons_valid, busy, buttons}, 12'h000);
        end
        @(negedge clock);
        reset = 1'b0;
        v0 = mon_valids;
        repeat (100) @(negedge clock);
        n_cmp++;
        if (mon_valids - v0 != 0 || buttons !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_no_valid: got valids %0d buttons %h expected 0 00", mon_valids - v0, buttons);
        end
        // poll in the same cycle as reset must be dropped
        reset = 1'b1;
        poll_enable = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        poll_enable = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || nes_latch !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wins_poll: got busy %b latch %b expected 0 0", busy, nes_latch);
        end
        run_read(8'h81, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h81 || valids != 1) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got %h valids %0d expected 81 1", got, valids);
        end
    endtask

    task automatic test_right_only();
        logic [7:0] exp;
        exp = 8'h01 << BTN_RIGHT;
        run_read(exp, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h80) begin n_bad++; $display("FAIL right_only: got %h expected %h", got, 8'h80); end
        n_cmp++;
        if (rises != 8 || bad_w != 0) begin
            n_bad++;
            $display("FAIL right_pulses: got %0d rises %0d bad widths expected 8 0", rises, bad_w);
        end
    endtask

    task automatic test_unplugged();
        pad_plugged = 1'b0;
        run_read(8'hFF, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'h00) begin n_bad++; $display("FAIL unplugged: got %h expected %h", got, 8'h00); end
        pad_plugged = 1'b1;
        pad_stuck_low = 1'b1;
        run_read(8'h00, 0, 0, got, valids, latch_n, rises, bad_w, latency);
        n_cmp++;
        if (got !== 8'hFF) begin n_bad++; $display("FAIL stuck_low: got %h expected %h", got, 8'hFF); end
        pad_stuck_low = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_patterns();
        test_poll_while_busy();
        test_reset_mid_read();
        test_right_only();
        test_unplugged();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
